// File: rtl/bcd_converter_seq.sv
// Iterative binary-to-BCD converter (shift-add-3, one input bit per clock).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active-low
//   in_valid   bin_in holds a word to convert
//   in_ready   converter is idle and can accept a word
//   bin_in     unsigned binary input, BIN_W bits
//   out_valid  bcd_out/overflow hold a finished result
//   out_ready  downstream consumes the result
//   bcd_out    packed BCD result, digit 0 (units) in [3:0]
//   overflow   value exceeded 10^DIGITS-1; bcd_out then holds the low digits only
//
// All outputs come from registers or from the state decode, so there is no
// combinational path from any input to any output.
module bcd_converter_seq #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [BIN_W-1:0]     bin_q,   bin_d;
    logic [BCD_W-1:0]     acc_q,   acc_d;
    logic [BCD_W-1:0]     bcd_q,   bcd_d;
    logic                 ovf_q,   ovf_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;

    // Accumulator after the per-digit add-3 correction, before the shift.
    logic [BCD_W-1:0]     acc_adj;

    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                // No carry between digits: a corrected digit is at most 12.
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    bin_d   = bin_in;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = StShift;
                end
            end

            StShift: begin
                acc_d = {acc_adj[BCD_W-2:0], bin_q[BIN_W-1]};
                bin_d = bin_q << 1;
                // A 1 leaving the top digit means the value needs more digits.
                if (acc_adj[BCD_W-1]) begin
                    ovf_d = 1'b1;
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Result register only changes on entry to DONE.
                    bcd_d   = acc_d;
                    state_d = StDone;
                end
            end

            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            bin_q   <= '0;
            acc_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign bcd_out   = bcd_q;
    assign overflow  = ovf_q;

endmodule
